// File: rtl/bp_dma_stride_engine_if.sv
// Descriptor, read/write stream and status signals of the 2D stride copy engine.
// The slave modport is the engine's view; master is the environment's view.
interface bp_dma_stride_engine_if #(
  parameter int unsigned paddr_width_p = 40,
  parameter int unsigned data_width_p  = 128,
  parameter int unsigned len_width_p   = 16
);
  logic [paddr_width_p-1:0] cfg_src_addr_i;
  logic [paddr_width_p-1:0] cfg_dst_addr_i;
  logic [len_width_p-1:0]   cfg_len_i;
  logic [len_width_p-1:0]   cfg_rows_i;
  logic [paddr_width_p-1:0] cfg_src_stride_i;
  logic [paddr_width_p-1:0] cfg_dst_stride_i;
  logic                     cfg_v_i;
  logic                     cfg_ready_and_o;
  logic                     abort_i;

  logic [paddr_width_p-1:0] rd_addr_o;
  logic                     rd_v_o;
  logic                     rd_ready_and_i;
  logic [data_width_p-1:0]  rd_data_i;
  logic                     rd_v_i;
  logic                     rd_ready_and_o;

  logic [paddr_width_p-1:0] wr_addr_o;
  logic [data_width_p-1:0]  wr_data_o;
  logic                     wr_v_o;
  logic                     wr_ready_and_i;
  logic                     wr_ack_v_i;

  logic                     busy_o;
  logic                     done_o;
  logic                     aborted_o;
  logic                     err_o;

  modport slave (
    input  cfg_src_addr_i, cfg_dst_addr_i, cfg_len_i, cfg_rows_i,
    input  cfg_src_stride_i, cfg_dst_stride_i, cfg_v_i, abort_i,
    output cfg_ready_and_o,
    output rd_addr_o, rd_v_o, rd_ready_and_o,
    input  rd_ready_and_i, rd_data_i, rd_v_i,
    output wr_addr_o, wr_data_o, wr_v_o,
    input  wr_ready_and_i, wr_ack_v_i,
    output busy_o, done_o, aborted_o, err_o
  );

  modport master (
    output cfg_src_addr_i, cfg_dst_addr_i, cfg_len_i, cfg_rows_i,
    output cfg_src_stride_i, cfg_dst_stride_i, cfg_v_i, abort_i,
    input  cfg_ready_and_o,
    input  rd_addr_o, rd_v_o, rd_ready_and_o,
    output rd_ready_and_i, rd_data_i, rd_v_i,
    input  wr_addr_o, wr_data_o, wr_v_o,
    output wr_ready_and_i, wr_ack_v_i,
    input  busy_o, done_o, aborted_o, err_o
  );
endinterface

// File: rtl/bp_dma_stride_engine.sv
// 2D strided memory-to-memory copy engine: bounded outstanding reads, credit-reserved
// beat buffer, write-ack tracking, abort and sticky aborted/error status.
module bp_dma_stride_engine #(
  parameter int unsigned paddr_width_p     = 40,
  parameter int unsigned data_width_p      = 128,
  parameter int unsigned len_width_p       = 16,
  parameter int unsigned max_outstanding_p = 4,
  parameter int unsigned buf_els_p         = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  bp_dma_stride_engine_if.slave bus
);
  localparam int unsigned AW         = paddr_width_p;
  localparam int unsigned DW         = data_width_p;
  localparam int unsigned LW         = len_width_p;
  localparam int unsigned TW         = 2 * len_width_p;
  localparam int unsigned OW         = $clog2(max_outstanding_p + 1);
  localparam int unsigned CW         = $clog2(buf_els_p + 1);
  localparam int unsigned PW         = (buf_els_p > 1) ? $clog2(buf_els_p) : 1;
  localparam int unsigned BEAT_BYTES = data_width_p / 8;

  typedef enum logic [1:0] {e_idle, e_run, e_drain, e_done} state_e;

  state_e          state_q;
  logic            cfg_ready_q, busy_q, done_q, aborted_q, err_q, abort_seen_q;
  logic            rd_v_q, wr_v_q;
  logic [LW-1:0]   len_q;
  logic [TW-1:0]   total_q;
  logic [AW-1:0]   src_stride_q, dst_stride_q;
  logic [AW-1:0]   rd_addr_q, rd_base_q, wr_addr_q, wr_base_q;
  logic [LW-1:0]   rd_col_q, wr_col_q;
  logic [TW-1:0]   rd_cnt_q, ack_cnt_q, unacked_q;
  logic [OW-1:0]   os_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [DW-1:0]   buf_mem [buf_els_p];

  logic            rd_hs, wr_hs, ret_ok, ack_ok, err_evt, push, rd_can_d;
  logic [TW-1:0]   total_d, rd_cnt_d, ack_cnt_d, unacked_d;
  logic [OW-1:0]   os_d;
  logic [CW-1:0]   cnt_d;
  logic [AW-1:0]   rd_addr_d, rd_base_d, wr_addr_d, wr_base_d;
  logic [LW-1:0]   rd_col_d, wr_col_d;
  logic [PW-1:0]   wptr_d, rptr_d;

  // Handshakes, credit counters and the two address walkers.
  always_comb begin
    rd_hs     = rd_v_q & bus.rd_ready_and_i;
    wr_hs     = wr_v_q & bus.wr_ready_and_i;
    ret_ok    = bus.rd_v_i & (os_q != '0);
    ack_ok    = bus.wr_ack_v_i & (unacked_q != '0);
    err_evt   = (bus.rd_v_i & (os_q == '0)) | (bus.wr_ack_v_i & (unacked_q == '0));
    // Returns after abort are accepted but never enter the buffer.
    push      = ret_ok & (state_q == e_run) & ~bus.abort_i;
    total_d   = TW'(bus.cfg_len_i) * TW'(bus.cfg_rows_i);
    os_d      = os_q + OW'(rd_hs) - OW'(ret_ok);
    cnt_d     = cnt_q + CW'(push) - CW'(wr_hs);
    unacked_d = unacked_q + TW'(wr_hs) - TW'(ack_ok);
    ack_cnt_d = ack_cnt_q + TW'(ack_ok);
    rd_cnt_d  = rd_cnt_q + TW'(rd_hs);
    rd_can_d  = (rd_cnt_d < total_q)
              && (32'(os_d) < max_outstanding_p)
              && ((32'(os_d) + 32'(cnt_d)) < buf_els_p);

    rd_addr_d = rd_addr_q;
    rd_base_d = rd_base_q;
    rd_col_d  = rd_col_q;
    if (rd_hs) begin
      if (rd_col_q == (len_q - LW'(1))) begin
        rd_col_d  = '0;
        rd_base_d = rd_base_q + src_stride_q;
        rd_addr_d = rd_base_q + src_stride_q;
      end else begin
        rd_col_d  = rd_col_q + LW'(1);
        rd_addr_d = rd_addr_q + AW'(BEAT_BYTES);
      end
    end

    wr_addr_d = wr_addr_q;
    wr_base_d = wr_base_q;
    wr_col_d  = wr_col_q;
    if (wr_hs) begin
      if (wr_col_q == (len_q - LW'(1))) begin
        wr_col_d  = '0;
        wr_base_d = wr_base_q + dst_stride_q;
        wr_addr_d = wr_base_q + dst_stride_q;
      end else begin
        wr_col_d  = wr_col_q + LW'(1);
        wr_addr_d = wr_addr_q + AW'(BEAT_BYTES);
      end
    end

    wptr_d = wptr_q;
    if (push) wptr_d = (wptr_q == PW'(buf_els_p - 1)) ? '0 : wptr_q + PW'(1);
    rptr_d = rptr_q;
    if (wr_hs) rptr_d = (rptr_q == PW'(buf_els_p - 1)) ? '0 : rptr_q + PW'(1);
  end

  // Beat storage; occupancy is tracked by cnt_q so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push) buf_mem[wptr_q] <= bus.rd_data_i;
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= e_idle;
      cfg_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      err_q        <= 1'b0;
      abort_seen_q <= 1'b0;
      rd_v_q       <= 1'b0;
      wr_v_q       <= 1'b0;
      len_q        <= '0;
      total_q      <= '0;
      src_stride_q <= '0;
      dst_stride_q <= '0;
      rd_addr_q    <= '0;
      rd_base_q    <= '0;
      rd_col_q     <= '0;
      wr_addr_q    <= '0;
      wr_base_q    <= '0;
      wr_col_q     <= '0;
      rd_cnt_q     <= '0;
      ack_cnt_q    <= '0;
      unacked_q    <= '0;
      os_q         <= '0;
      cnt_q        <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
    end else begin
      os_q      <= os_d;
      cnt_q     <= cnt_d;
      unacked_q <= unacked_d;
      ack_cnt_q <= ack_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_addr_q <= rd_addr_d;
      rd_base_q <= rd_base_d;
      rd_col_q  <= rd_col_d;
      wr_addr_q <= wr_addr_d;
      wr_base_q <= wr_base_d;
      wr_col_q  <= wr_col_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      if (err_evt) err_q <= 1'b1;

      case (state_q)
        e_idle: begin
          if (bus.cfg_v_i) begin
            state_q      <= e_run;
            cfg_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            aborted_q    <= 1'b0;
            abort_seen_q <= 1'b0;
            err_q        <= err_evt;
            len_q        <= bus.cfg_len_i;
            total_q      <= total_d;
            src_stride_q <= bus.cfg_src_stride_i;
            dst_stride_q <= bus.cfg_dst_stride_i;
            rd_addr_q    <= bus.cfg_src_addr_i;
            rd_base_q    <= bus.cfg_src_addr_i;
            rd_col_q     <= '0;
            wr_addr_q    <= bus.cfg_dst_addr_i;
            wr_base_q    <= bus.cfg_dst_addr_i;
            wr_col_q     <= '0;
            rd_cnt_q     <= '0;
            ack_cnt_q    <= '0;
            rd_v_q       <= (total_d != '0);
          end
        end
        e_run: begin
          if (bus.abort_i) begin
            state_q      <= e_drain;
            abort_seen_q <= 1'b1;
            rd_v_q       <= 1'b0;
            wr_v_q       <= 1'b0;
            cnt_q        <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
          end else if (ack_cnt_q == total_q) begin
            state_q <= e_drain;
            rd_v_q  <= 1'b0;
            wr_v_q  <= 1'b0;
          end else begin
            rd_v_q <= rd_can_d;
            wr_v_q <= (cnt_d != '0);
          end
        end
        e_drain: begin
          if ((os_q == '0) && (unacked_q == '0)) begin
            state_q   <= e_done;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            aborted_q <= abort_seen_q;
          end
        end
        e_done: begin
          state_q     <= e_idle;
          done_q      <= 1'b0;
          cfg_ready_q <= 1'b1;
        end
        default: state_q <= e_idle;
      endcase
    end
  end

  assign bus.cfg_ready_and_o = cfg_ready_q;
  assign bus.rd_addr_o       = rd_addr_q;
  assign bus.rd_v_o          = rd_v_q;
  assign bus.rd_ready_and_o  = 1'b1;
  assign bus.wr_addr_o       = wr_addr_q;
  assign bus.wr_data_o       = buf_mem[rptr_q];
  assign bus.wr_v_o          = wr_v_q;
  assign bus.busy_o          = busy_q;
  assign bus.done_o          = done_q;
  assign bus.aborted_o       = aborted_q;
  assign bus.err_o           = err_q;
endmodule

// File: tb/tb_bp_dma_stride_engine.sv
// Directed bench for bp_dma_stride_engine: a throttled memory responder plus a linear
// sequence of descriptors checked against hand-computed addresses, counts and timing.
module tb_bp_dma_stride_engine;
  localparam int unsigned AW  = 40;
  localparam int unsigned DW  = 128;
  localparam int unsigned LW  = 16;
  localparam int          BIG = 32'h4000_0000;

  logic clk = 1'b0;
  logic reset_n_i;
  always #5 clk = ~clk;

  bp_dma_stride_engine_if #(.paddr_width_p(AW), .data_width_p(DW), .len_width_p(LW)) bus ();

  bp_dma_stride_engine #(
    .paddr_width_p(AW), .data_width_p(DW), .len_width_p(LW),
    .max_outstanding_p(4), .buf_els_p(8)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n_i),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Allowances written only by the stimulus; counters written only by the responder.
  int rd_allow, ret_allow, wr_allow, ack_allow, inj_ret_allow, inj_ack_allow;
  int rd_issued, ret_count, wr_issued, ack_count, inj_ret_cnt, inj_ack_cnt, ack_pend;
  logic [DW-1:0] pend_q [$];
  logic [AW-1:0] rd_log [$];
  logic [AW-1:0] wr_alog [$];
  logic [DW-1:0] wr_dlog [$];

  logic [AW-1:0] t2_rd [6] = '{40'h1000, 40'h1010, 40'h1100, 40'h1110, 40'h1200, 40'h1210};
  logic [AW-1:0] t2_wr [6] = '{40'h2000, 40'h2010, 40'h2040, 40'h2050, 40'h2080, 40'h2090};

  function automatic logic [DW-1:0] mk_data(input logic [AW-1:0] a);
    return {24'hA5A5A5, a, 24'h5A5A5A, ~a};
  endfunction

  // Memory model: in-order returns of earlier accepted reads, delayed write acks.
  always @(negedge clk) begin
    if (!reset_n_i) begin
      bus.rd_ready_and_i = 1'b0;
      bus.rd_v_i         = 1'b0;
      bus.rd_data_i      = '0;
      bus.wr_ready_and_i = 1'b0;
      bus.wr_ack_v_i     = 1'b0;
      rd_issued = 0; ret_count = 0; wr_issued = 0; ack_count = 0;
      inj_ret_cnt = 0; inj_ack_cnt = 0; ack_pend = 0;
      pend_q.delete(); rd_log.delete(); wr_alog.delete(); wr_dlog.delete();
    end else begin
      bus.rd_v_i    = 1'b0;
      bus.rd_data_i = '0;
      if (pend_q.size() > 0 && ret_count < ret_allow) begin
        bus.rd_v_i    = 1'b1;
        bus.rd_data_i = pend_q.pop_front();
        ret_count++;
      end else if (inj_ret_cnt < inj_ret_allow) begin
        bus.rd_v_i = 1'b1;
        inj_ret_cnt++;
      end
      bus.wr_ack_v_i = 1'b0;
      if (ack_pend > 0 && ack_count < ack_allow) begin
        bus.wr_ack_v_i = 1'b1;
        ack_pend--;
        ack_count++;
      end else if (inj_ack_cnt < inj_ack_allow) begin
        bus.wr_ack_v_i = 1'b1;
        inj_ack_cnt++;
      end
      bus.rd_ready_and_i = (rd_issued < rd_allow);
      if (bus.rd_v_o && bus.rd_ready_and_i) begin
        rd_log.push_back(bus.rd_addr_o);
        pend_q.push_back(mk_data(bus.rd_addr_o));
        rd_issued++;
      end
      bus.wr_ready_and_i = (wr_issued < wr_allow);
      if (bus.wr_v_o && bus.wr_ready_and_i) begin
        wr_alog.push_back(bus.wr_addr_o);
        wr_dlog.push_back(bus.wr_data_o);
        ack_pend++;
        wr_issued++;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic open_all();
    rd_allow = BIG; ret_allow = BIG; wr_allow = BIG; ack_allow = BIG;
  endtask

  task automatic do_reset();
    open_all();
    inj_ret_allow = 0; inj_ack_allow = 0;
    bus.cfg_v_i = 1'b0;
    bus.abort_i = 1'b0;
    reset_n_i   = 1'b0;
    step();
    step();
    reset_n_i = 1'b1;
  endtask

  task automatic start(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                       input logic [LW-1:0] len, input logic [LW-1:0] rows,
                       input logic [AW-1:0] ss, input logic [AW-1:0] ds);
    bus.cfg_src_addr_i   = src;
    bus.cfg_dst_addr_i   = dst;
    bus.cfg_len_i        = len;
    bus.cfg_rows_i       = rows;
    bus.cfg_src_stride_i = ss;
    bus.cfg_dst_stride_i = ds;
    bus.cfg_v_i          = 1'b1;
    step();
    bus.cfg_v_i = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (bus.done_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    reset_n_i = 1'b0;
    bus.cfg_src_addr_i = '0; bus.cfg_dst_addr_i = '0;
    bus.cfg_len_i = '0; bus.cfg_rows_i = '0;
    bus.cfg_src_stride_i = '0; bus.cfg_dst_stride_i = '0;
    do_reset();

    // Reset state
    chk("rst_cfg_ready", 64'(bus.cfg_ready_and_o), 64'd1);
    chk("rst_rd_ready",  64'(bus.rd_ready_and_o),  64'd1);
    chk("rst_busy",      64'(bus.busy_o),          64'd0);
    chk("rst_done",      64'(bus.done_o),          64'd0);
    chk("rst_aborted",   64'(bus.aborted_o),       64'd0);
    chk("rst_err",       64'(bus.err_o),           64'd0);
    chk("rst_rd_v",      64'(bus.rd_v_o),          64'd0);
    chk("rst_wr_v",      64'(bus.wr_v_o),          64'd0);

    // 1: single row of 4 beats
    start(40'h1000, 40'h2000, 16'd4, 16'd1, 40'h0, 40'h0);
    chk("t1_rd_v_first", 64'(bus.rd_v_o),          64'd1);
    chk("t1_rd_addr0",   64'(bus.rd_addr_o),       64'h1000);
    chk("t1_busy",       64'(bus.busy_o),          64'd1);
    chk("t1_cfg_ready",  64'(bus.cfg_ready_and_o), 64'd0);
    wait_done(200, ok);
    chk("t1_done_seen", 64'(ok),        64'd1);
    chk("t1_acks",      64'(ack_count), 64'd4);
    chk("t1_aborted",   64'(bus.aborted_o), 64'd0);
    chk("t1_rd_n",      64'(rd_log.size()),  64'd4);
    chk("t1_wr_n",      64'(wr_alog.size()), 64'd4);
    if (rd_log.size() == 4 && wr_alog.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t1_rd%0d", i), 64'(rd_log[i]),  64'(40'h1000 + 40'(i * 16)));
        chk($sformatf("t1_wr%0d", i), 64'(wr_alog[i]), 64'(40'h2000 + 40'(i * 16)));
        chk_w($sformatf("t1_wd%0d", i), wr_dlog[i], mk_data(40'h1000 + 40'(i * 16)));
      end
    end
    step();
    chk("t1_done_pulse", 64'(bus.done_o),          64'd0);
    chk("t1_idle_ready", 64'(bus.cfg_ready_and_o), 64'd1);

    // 2: 3 rows of 2 beats, independent strides
    do_reset();
    start(40'h1000, 40'h2000, 16'd2, 16'd3, 40'h100, 40'h40);
    wait_done(300, ok);
    chk("t2_done_seen", 64'(ok), 64'd1);
    chk("t2_rd_n", 64'(rd_log.size()),  64'd6);
    chk("t2_wr_n", 64'(wr_alog.size()), 64'd6);
    if (rd_log.size() == 6 && wr_alog.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("t2_rd%0d", i), 64'(rd_log[i]),  64'(t2_rd[i]));
        chk($sformatf("t2_wr%0d", i), 64'(wr_alog[i]), 64'(t2_wr[i]));
        chk_w($sformatf("t2_wd%0d", i), wr_dlog[i], mk_data(t2_rd[i]));
      end
    end

    // 3: outstanding-read limit, then buffer-credit limit
    do_reset();
    ret_allow = 0;
    start(40'h1000, 40'h2000, 16'd32, 16'd1, 40'h0, 40'h0);
    for (int i = 0; i < 20; i++) step();
    chk("t3_os_limit_reads", 64'(rd_issued),  64'd4);
    chk("t3_os_limit_rd_v",  64'(bus.rd_v_o), 64'd0);
    wr_allow  = 0;
    ret_allow = BIG;
    for (int i = 0; i < 30; i++) step();
    chk("t3_buf_limit_reads", 64'(rd_issued),  64'd8);
    chk("t3_buf_limit_rets",  64'(ret_count),  64'd8);
    chk("t3_buf_limit_wr",    64'(wr_issued),  64'd0);
    chk("t3_buf_limit_rd_v",  64'(bus.rd_v_o), 64'd0);
    chk("t3_buf_limit_wr_v",  64'(bus.wr_v_o), 64'd1);
    wr_allow = BIG;
    wait_done(1000, ok);
    chk("t3_done_seen", 64'(ok),        64'd1);
    chk("t3_rd_total",  64'(rd_issued), 64'd32);
    chk("t3_wr_total",  64'(wr_issued), 64'd32);
    if (wr_dlog.size() == 32) begin
      for (int i = 0; i < 32; i++)
        chk_w($sformatf("t3_wd%0d", i), wr_dlog[i], mk_data(40'h1000 + 40'(i * 16)));
    end

    // 4: zero-length descriptor completes in fixed time
    do_reset();
    start(40'h1000, 40'h2000, 16'd0, 16'd5, 40'h0, 40'h0);
    chk("t4_done_c1", 64'(bus.done_o), 64'd0);
    step();
    chk("t4_done_c2", 64'(bus.done_o), 64'd0);
    step();
    chk("t4_done_c3",  64'(bus.done_o),    64'd1);
    chk("t4_aborted",  64'(bus.aborted_o), 64'd0);
    chk("t4_busy",     64'(bus.busy_o),    64'd0);
    step();
    chk("t4_done_off", 64'(bus.done_o),    64'd0);
    chk("t4_no_rd",    64'(rd_issued),     64'd0);
    chk("t4_no_wr",    64'(wr_issued),     64'd0);

    // 5: abort with 2 reads in flight and 1 write unacked
    do_reset();
    rd_allow = 3; ret_allow = 1; wr_allow = 1; ack_allow = 0;
    start(40'h1000, 40'h2000, 16'd16, 16'd1, 40'h0, 40'h0);
    for (int i = 0; i < 100 && wr_issued < 1; i++) step();
    for (int i = 0; i < 5; i++) step();
    chk("t5_pre_reads",  64'(rd_issued),  64'd3);
    chk("t5_pre_writes", 64'(wr_issued),  64'd1);
    chk("t5_pre_rd_v",   64'(bus.rd_v_o), 64'd1);
    bus.abort_i = 1'b1;
    step();
    bus.abort_i = 1'b0;
    chk("t5_abort_rd_v", 64'(bus.rd_v_o), 64'd0);
    chk("t5_abort_wr_v", 64'(bus.wr_v_o), 64'd0);
    chk("t5_abort_busy", 64'(bus.busy_o), 64'd1);
    open_all();
    wait_done(200, ok);
    chk("t5_done_seen", 64'(ok),            64'd1);
    chk("t5_rets",      64'(ret_count),     64'd3);
    chk("t5_acks",      64'(ack_count),     64'd1);
    chk("t5_reads",     64'(rd_issued),     64'd3);
    chk("t5_writes",    64'(wr_issued),     64'd1);
    chk("t5_aborted",   64'(bus.aborted_o), 64'd1);
    step();
    chk("t5_aborted_sticky", 64'(bus.aborted_o), 64'd1);

    // 6: unexpected return in idle, stray ack mid-run, then reset mid-run
    inj_ret_allow = 1;
    for (int i = 0; i < 3; i++) step();
    chk("t6_err_idle_ret", 64'(bus.err_o), 64'd1);
    ret_allow = 0;
    start(40'h3000, 40'h4000, 16'd8, 16'd1, 40'h0, 40'h0);
    chk("t6_err_cleared",     64'(bus.err_o),     64'd0);
    chk("t6_aborted_cleared", 64'(bus.aborted_o), 64'd0);
    for (int i = 0; i < 3; i++) step();
    inj_ack_allow = 1;
    for (int i = 0; i < 3; i++) step();
    chk("t6_err_stray_ack", 64'(bus.err_o),  64'd1);
    chk("t6_busy_mid",      64'(bus.busy_o), 64'd1);
    inj_ret_allow = 0;
    inj_ack_allow = 0;
    open_all();
    reset_n_i = 1'b0;
    step();
    chk("t6_rst_busy",      64'(bus.busy_o),          64'd0);
    chk("t6_rst_cfg_ready", 64'(bus.cfg_ready_and_o), 64'd1);
    chk("t6_rst_err",       64'(bus.err_o),           64'd0);
    chk("t6_rst_rd_v",      64'(bus.rd_v_o),          64'd0);
    step();
    reset_n_i = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
